// File: rtl/adld_sqrt_feeder_if.sv
// Stream and core-handshake bundle for adld_sqrt_feeder.
// slave is the feeder's view; master is the upstream/core/consumer view.
interface adld_sqrt_feeder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_rad;
    logic             sq_start;
    logic [WIDTH-1:0] sq_rad;
    logic             sq_busy;
    logic             sq_valid;
    logic [WIDTH-1:0] sq_root;
    logic [WIDTH-1:0] sq_rem;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_rad;
    logic [WIDTH-1:0] out_root;
    logic [WIDTH-1:0] out_rem;
    logic             out_err;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_rad, sq_busy, sq_valid, sq_root, sq_rem, out_ready,
        output in_ready, sq_start, sq_rad, out_valid, out_rad, out_root, out_rem,
               out_err, count
    );

    modport master (
        output in_valid, in_rad, sq_busy, sq_valid, sq_root, sq_rem, out_ready,
        input  in_ready, sq_start, sq_rad, out_valid, out_rad, out_root, out_rem,
               out_err, count
    );
endinterface

// File: rtl/adld_sqrt_feeder.sv
// Request stage for the sequential square-root core: radicand FIFO, issue FSM, result hold.
// Defining SQRT_FEEDER_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
module adld_sqrt_feeder #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input logic               clk,
    input logic               rst,
    adld_sqrt_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] cur_rad;
    logic [WIDTH-1:0] sq_rad;
    logic [WIDTH-1:0] out_rad;
    logic [WIDTH-1:0] out_root;
    logic [WIDTH-1:0] out_rem;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic             finish;
    logic             timeout_hit;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push         = bus.in_valid && (count != FULL);
    assign bus.in_ready = (count != FULL);
    assign bus.count    = count;
    assign bus.sq_rad   = sq_rad;
    assign bus.out_rad  = out_rad;
    assign bus.out_root = out_root;
    assign bus.out_rem  = out_rem;
    assign bus.out_valid = out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        finish       = 1'b0;
        bus.sq_start = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !bus.sq_busy && !out_valid) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.sq_start = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (bus.sq_valid || timeout_hit) begin
                    finish     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_rad;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cur_rad   <= '0;
            sq_rad    <= '0;
            out_valid <= 1'b0;
            out_rad   <= '0;
            out_root  <= '0;
            out_rem   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                cur_rad <= mem[rd_ptr];
                sq_rad  <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A real core result beats a coincident timeout; an abort reports zeros.
            if (finish) begin
                out_root  <= bus.sq_valid ? bus.sq_root : '0;
                out_rem   <= bus.sq_valid ? bus.sq_rem : '0;
                out_rad   <= cur_rad;
                out_valid <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SQRT_FEEDER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;
    logic          out_err;

    assign timeout_hit = (tmo_cnt == LIMIT);
    assign bus.out_err = out_err;

    // Counter starts from zero on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            out_err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (finish) begin
                out_err <= !bus.sq_valid;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus.out_err = 1'b0;
`endif
endmodule
